// File: rtl/set_cmp_pkg.sv
// Shared definitions for the serial set-compare engine: opcodes, FSM states
// and the flag-to-condition mapping.
package set_cmp_pkg;

    localparam int unsigned DATA_W = 32;

    localparam logic [2:0] OP_SLT = 3'b000;
    localparam logic [2:0] OP_SEQ = 3'b001;
    localparam logic [2:0] OP_SNE = 3'b010;
    localparam logic [2:0] OP_SGT = 3'b011;
    localparam logic [2:0] OP_SLE = 3'b100;
    localparam logic [2:0] OP_SGE = 3'b101;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    // Sign is taken from the wrapped difference; no overflow correction.
    function automatic logic cond_flag(input logic [2:0] op, input logic sign,
                                       input logic zf);
        logic flag;
        case (op)
            OP_SLT:  flag = sign;
            OP_SEQ:  flag = zf;
            OP_SNE:  flag = ~zf;
            OP_SGT:  flag = ~zf & ~sign;
            OP_SLE:  flag = zf | sign;
            OP_SGE:  flag = ~sign;
            default: flag = 1'b0;
        endcase
        return flag;
    endfunction

endpackage

// File: rtl/sub_digit.sv
// One digit slice of the subtractor: a + ~b + carry_in, with carry out.
module sub_digit #(
    parameter int unsigned DIGIT_W = 4
) (
    input  logic [DIGIT_W-1:0] a_digit,
    input  logic [DIGIT_W-1:0] nb_digit,
    input  logic               cin,
    output logic [DIGIT_W-1:0] sum,
    output logic               cout
);

    always_comb begin
        {cout, sum} = {1'b0, a_digit} + {1'b0, nb_digit} + {{DIGIT_W{1'b0}}, cin};
    end

endmodule

// File: rtl/serial_set_cmp.sv
// Digit-serial a - b engine producing set-instruction results; operands are
// shifted right one digit per cycle and the difference is shifted in from the top.
module serial_set_cmp
    import set_cmp_pkg::*;
#(
    parameter int unsigned DIGIT_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic [2:0]        in_op,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_set,
    output logic [DATA_W-1:0] out_diff,
    output logic              out_zf,
    output logic              out_nz
);

    localparam int unsigned N     = DATA_W / DIGIT_W;
    localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    state_e             state_q;
    logic [DATA_W-1:0]  a_q;
    logic [DATA_W-1:0]  b_q;
    logic [DATA_W-1:0]  diff_q;
    logic [2:0]         op_q;
    logic               carry_q;
    logic               zero_q;
    logic [CNT_W-1:0]   cnt_q;

    logic [DIGIT_W-1:0] sum;
    logic               cout;
    logic [DATA_W-1:0]  diff_next;
    logic               zero_next;

    sub_digit #(
        .DIGIT_W (DIGIT_W)
    ) u_sub_digit (
        .a_digit  (a_q[DIGIT_W-1:0]),
        .nb_digit (~b_q[DIGIT_W-1:0]),
        .cin      (carry_q),
        .sum      (sum),
        .cout     (cout)
    );

    always_comb begin
        diff_next = {sum, diff_q[DATA_W-1:DIGIT_W]};
        zero_next = zero_q & ~(|sum);
    end

    assign in_ready = (state_q == StIdle);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            a_q       <= '0;
            b_q       <= '0;
            diff_q    <= '0;
            op_q      <= '0;
            carry_q   <= 1'b0;
            zero_q    <= 1'b0;
            cnt_q     <= '0;
            out_valid <= 1'b0;
            out_set   <= '0;
            out_diff  <= '0;
            out_zf    <= 1'b0;
            out_nz    <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        a_q     <= in_a;
                        b_q     <= in_b;
                        op_q    <= in_op;
                        carry_q <= 1'b1;
                        zero_q  <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    a_q     <= a_q >> DIGIT_W;
                    b_q     <= b_q >> DIGIT_W;
                    diff_q  <= diff_next;
                    carry_q <= cout;
                    zero_q  <= zero_next;
                    cnt_q   <= cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        out_diff  <= diff_next;
                        out_zf    <= zero_next;
                        out_nz    <= ~zero_next;
                        out_set   <= {{(DATA_W-1){1'b0}},
                                      cond_flag(op_q, diff_next[DATA_W-1], zero_next)};
                        out_valid <= 1'b1;
                        state_q   <= StDone;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state_q   <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: doc/serial_set_cmp.md
# serial_set_cmp

Multi-cycle compare engine that produces the 32-bit set-instruction results (SLT, SEQ, SNE, SGT, SLE, SGE) from two register operands. It computes `a - b` four bits per cycle, derives the sign, zero and not-zero conditions, and formats the result as `{31'b0, flag}`. It sits between operand fetch and writeback as an area-cheap alternative to the full-width adder path. Valid/ready handshakes on both sides.

## Interface
- `DIGIT_W`, default 4: bits processed per cycle; must divide 32; cycle count `N = 32/DIGIT_W`.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous reset, active-high.
- `in_valid`  in  1  operand/opcode offer.
- `in_ready`  out  1  engine idle; high only in IDLE.
- `in_a`  in  32  minuend.
- `in_b`  in  32  subtrahend.
- `in_op`  in  3  opcode: 000 SLT, 001 SEQ, 010 SNE, 011 SGT, 100 SLE, 101 SGE, 110/111 reserved.
- `out_valid`  out  1  result held.
- `out_ready`  in  1  consumer accepts.
- `out_set`  out  32  `{31'b0, flag}`.
- `out_diff`  out  32  `a - b` modulo 2^32.
- `out_zf`  out  1  diff == 0.
- `out_nz`  out  1  diff != 0.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: `in_ready=1`. When `in_valid` is high, latch a, b and op; set carry=1, zero_acc=1, digit index=0; go to RUN.
- RUN: each cycle, add digit `i` of `a` to `~b` plus carry. Store the sum digit into diff[i], update carry, and clear zero_acc if the sum digit is nonzero. After digit N-1, go to DONE.
- DONE: `out_valid=1`. Outputs stay stable until `out_ready` is high; on that handshake go to IDLE.
- Flags: sign = diff[31], zf = zero_acc, nz = ~zero_acc.
- Condition per op:
  - SLT = sign
  - SEQ = zf
  - SNE = nz
  - SGT = nz & ~sign
  - SLE = zf | sign
  - SGE = ~sign
  - reserved = 0
- Signedness is decided as the sign of the wrapped difference with no overflow correction. This matches the downstream set units bit-for-bit.
- No new input is accepted while in RUN or DONE; `in_valid` is ignored there.
- Reset (any state, including mid-RUN): state = IDLE, `in_ready=1`, `out_valid=0`, `out_set=0`, `out_diff=0`, `out_zf=0`, `out_nz=0`. All internal registers are cleared and the partial result is discarded.

## Timing
- Input accept at edge T0.
- RUN occupies edges T1..TN; with the default `DIGIT_W`, N=8.
- `out_valid` rises after edge TN and is visible in cycle N+1.
- Throughput: one op per N+2 cycles when `out_ready` is tied high.
- The IDLE→accept path is not combinational from `out_ready`. After the DONE handshake, the next input is accepted one cycle later, at earliest.
- `out_*` are registered; no combinational path from inputs to outputs.
- `in_ready` is derived only from the state register.

## Structure
- Shared package `set_cmp_pkg`: opcode localparams (`OP_SLT`…`OP_SGE`), state enum (IDLE/RUN/DONE), `DATA_W=32`.
- Sub-module `sub_digit`: combinational `DIGIT_W`-bit adder taking a digit, the inverted b-digit and carry-in; outputs the sum digit and carry-out. Instanced once.
- Top module: FSM, digit counter (`$clog2(N)` bits), operand and diff registers, opcode decode.

## Test plan
- a=5, b=7, op=SLT → out_diff=0xFFFFFFFE, out_set=1, zf=0, nz=1; out_valid first seen 9 cycles after accept.
- a=b=0x00001234, op=SEQ → diff=0, out_set=1, zf=1, nz=0. Repeat with op=SNE → out_set=0. Repeat with op=SLE → out_set=1.
- a=0x80000000, b=1, op=SLT → diff=0x7FFFFFFF, out_set=0 (wrap, no overflow correction). Same operands with op=SGT → out_set=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE → out_set, out_diff and flags stay constant, in_ready=0, and a new in_valid is ignored. Releasing out_ready → IDLE the next cycle.
- Reset pulse at RUN cycle 4 → next cycle IDLE with all outputs 0. A fresh op a=9, b=3, SGE completes normally with out_set=1 and diff=6.
- Reserved op 110 with a=1, b=2 → out_set=0, diff=0xFFFFFFFF. Back-to-back ops with out_ready=1 complete every 10 cycles.
